traffic_request_conditioner: RTL and testbench
==============================================

// Module: traffic_request_conditioner
// PURPOSE
//   Upstream front-end for the 4-way traffic light FSM. Synchronises and debounces
//   four raw vehicle-loop sensors, one per approach.
//   Holds each detection as a sticky request until that approach is served (its
//   green lamp is on). Drives the FSM request inputs A..D from req[0..3].
//   Flags approaches that have waited too long (starve) so supervisory logic can act.
// PARAMETERS
//   DEBOUNCE_CYCLES  4    consecutive stable synchronised samples needed to accept a sensor change (>=1)
//   STARVE_LIMIT     20   cycles a pending, ungranted request may wait before starve asserts (>=1)
// PORTS
//   clk     in   1  system clock, all logic on rising edge
//   reset   in   1  synchronous, active-high; clears all state
//   sensor  in   4  raw loop detectors, asynchronous; bit0=north, 1=east, 2=south, 3=west
//   grant   in   4  green lamps from FSM {green_west,green_south,green_east,green_north}
//   req     out  4  registered sticky requests; req[0..3] drive FSM A,B,C,D
//   starve  out  4  registered; lane pending >= STARVE_LIMIT cycles without grant
// BEHAVIOUR
//   Reset (sync, sampled at clk edge with reset=1):
//   - sync flops, db_state, db_cnt, wait_cnt, req and starve all go to 0.
//   - Reset wins over every other event in the same cycle.
//   Per-lane pipeline, 4 identical independent lanes:
//   - Sync: 2-flop synchroniser sensor -> s1 -> s2. No other use of raw sensor.
//   - Debounce: db_state (1b) with db_cnt (clog2(DEBOUNCE_CYCLES+1) bits).
//     - If s2==db_state: db_cnt<=0.
//     - Else if db_cnt==DEBOUNCE_CYCLES-1: db_state<=s2, db_cnt<=0.
//     - Else db_cnt<=db_cnt+1.
//     - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes db_state.
//     - Applies symmetrically to rising and falling changes.
//   - Request: req_next = grant ? 0 : (req | db_state).
//     - grant has priority: req is held low for every cycle grant is high, even if db_state=1.
//     - Sticky: req stays 1 after db_state falls (vehicle left) until granted.
//     - Re-request: db_state still 1 when grant falls -> req re-asserts on the next edge (queued traffic).
//   - Latency: sensor rising and held from sampling edge k (edge 1)
//     -> db_state=1 on edge k+DEBOUNCE_CYCLES+1
//     -> req=1 on edge k+DEBOUNCE_CYCLES+2, i.e. the (DEBOUNCE_CYCLES+3)th edge.
//   - Wait counter: wait_cnt (clog2(STARVE_LIMIT+1) bits).
//     - grant=1 or req=0: wait_cnt<=0.
//     - Otherwise it increments by 1, saturating at STARVE_LIMIT; it never wraps.
//   - starve<= (wait_cnt_next==STARVE_LIMIT); clears on the same edge as req clears on grant.
//   - Simultaneous events:
//     - db_state rising in the same cycle as grant -> req stays 0 that edge, sets the edge after grant drops.
//     - Multiple lanes may be pending and starving at once; no arbitration here (the FSM arbitrates).
//   - Reset mid-debounce or mid-wait discards all progress. A sensor held high through
//     reset needs a full 2+DEBOUNCE_CYCLES+1 cycles after reset release to re-request.
//   - X on grant is not tolerated; the bench drives grant to known values from reset.
// TESTING (DEBOUNCE_CYCLES=4, STARVE_LIMIT=20)
//   1. Reset 3 cycles, sensor=0, grant=0 -> req=0000, starve=0000 throughout; then sensor[1] high held
//      -> req=0010 exactly on the 7th edge after sensor first sampled high, not before.
//   2. sensor[2] pulses high for 3 cycles -> req[2] never asserts; a 4-cycle pulse (post-sync) -> req[2]=1
//      and stays 1 after sensor drops.
//   3. req[0]=1, sensor[0] released, grant=0001 for 1 cycle -> req[0]=0 on that edge and remains 0;
//      with sensor[0] still held -> req[0] returns to 1 on the edge after grant falls.
//   4. req[3]=1, grant=0000 -> starve[3]=1 on the 20th edge after req[3] rose, stays 1 (saturated)
//      for 100 more cycles; grant[3]=1 -> req[3]=0 and starve[3]=0 on the same edge.
//   5. All 4 sensors high, grant rotates 0001->0010->0100->1000 one cycle each -> only the granted bit is 0
//      each cycle; the bit re-asserts one cycle after its grant ends.
//   6. sensor[1] high, reset pulsed when db_cnt=2 -> all outputs 0 next edge; req[1] reasserts only
//      7 edges after reset release.

Source files
------------

// File: rtl/traffic_request_conditioner.sv
// ============================================================================
// Module   : traffic_request_conditioner
// Brief    : Sync, debounce and latch four loop sensors into sticky FSM requests
//            with per-lane starvation flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module traffic_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STARVE_LIMIT    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sensor,
    input  logic [3:0] grant,
    output logic [3:0] req,
    output logic [3:0] starve
);

    localparam int NLANES = 4;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(STARVE_LIMIT);

    logic [NLANES-1:0] s1_q, s2_q;
    logic [NLANES-1:0] db_state_q, db_state_d;
    logic [DB_W-1:0]   db_cnt_q   [NLANES];
    logic [DB_W-1:0]   db_cnt_d   [NLANES];
    logic [NLANES-1:0] req_q, req_d;
    logic [WAIT_W-1:0] wait_cnt_q [NLANES];
    logic [WAIT_W-1:0] wait_cnt_d [NLANES];
    logic [NLANES-1:0] starve_q, starve_d;

    always_comb begin
        db_state_d = db_state_q;
        req_d      = req_q;
        starve_d   = starve_q;
        for (int l = 0; l < NLANES; l++) begin
            db_cnt_d[l]   = db_cnt_q[l];
            wait_cnt_d[l] = wait_cnt_q[l];

            // Counter only advances while the synchronised input disagrees with
            // the accepted state, so any agreeing sample restarts the run.
            if (s2_q[l] == db_state_q[l]) begin
                db_cnt_d[l] = '0;
            end else if (db_cnt_q[l] == DB_LAST) begin
                db_state_d[l] = s2_q[l];
                db_cnt_d[l]   = '0;
            end else begin
                db_cnt_d[l] = db_cnt_q[l] + 1'b1;
            end

            req_d[l] = grant[l] ? 1'b0 : (req_q[l] | db_state_q[l]);

            if (grant[l] || !req_q[l]) begin
                wait_cnt_d[l] = '0;
            end else if (wait_cnt_q[l] != WAIT_SAT) begin
                wait_cnt_d[l] = wait_cnt_q[l] + 1'b1;
            end

            starve_d[l] = (wait_cnt_d[l] == WAIT_SAT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            db_state_q <= '0;
            req_q      <= '0;
            starve_q   <= '0;
            for (int l = 0; l < NLANES; l++) begin
                db_cnt_q[l]   <= '0;
                wait_cnt_q[l] <= '0;
            end
        end else begin
            s1_q       <= sensor;
            s2_q       <= s1_q;
            db_state_q <= db_state_d;
            req_q      <= req_d;
            starve_q   <= starve_d;
            for (int l = 0; l < NLANES; l++) begin
                db_cnt_q[l]   <= db_cnt_d[l];
                wait_cnt_q[l] <= wait_cnt_d[l];
            end
        end
    end

    assign req    = req_q;
    assign starve = starve_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_request_conditioner.sv
// ============================================================================
// Module   : tb_traffic_request_conditioner
// Brief    : Scoreboarded bench for traffic_request_conditioner (D=4, LIMIT=20).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_traffic_request_conditioner;

    localparam int DB = 4;
    localparam int SL = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sensor = 4'b0000;
    logic [3:0] grant  = 4'b0000;
    logic [3:0] req;
    logic [3:0] starve;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q [$];

    // Reference state: sensor history per lane and samples since last accepted change
    logic [3:0]    m_s1 = '0, m_s2 = '0, m_db = '0, m_req = '0, m_starve = '0;
    logic [DB-1:0] m_hist [4];
    int            m_age  [4];
    int            m_wait [4];

    traffic_request_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .STARVE_LIMIT   (SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sensor(sensor),
        .grant (grant),
        .req   (req),
        .starve(starve)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] s, input logic [3:0] g, input logic r);
        logic [3:0] new_db;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_req = '0; m_starve = '0;
            for (int l = 0; l < 4; l++) begin
                m_hist[l] = '0; m_age[l] = 0; m_wait[l] = 0;
            end
        end else begin
            new_db = m_db;
            for (int l = 0; l < 4; l++) begin
                m_hist[l] = {m_hist[l][DB-2:0], m_s2[l]};
                m_age[l]++;
                // Accept a change only after DB fresh samples all disagree
                if (m_age[l] >= DB && m_hist[l] == (m_db[l] ? {DB{1'b0}} : {DB{1'b1}})) begin
                    new_db[l] = ~m_db[l];
                    m_age[l]  = 0;
                end
                if (g[l] || !m_req[l]) m_wait[l] = 0;
                else if (m_wait[l] < SL) m_wait[l]++;
                m_starve[l] = (m_wait[l] == SL);
                m_req[l]    = g[l] ? 1'b0 : (m_req[l] | m_db[l]);
            end
            m_s2 = m_s1;
            m_s1 = s;
            m_db = new_db;
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [3:0] g, input logic r);
        logic [7:0] e;
        @(negedge clk);
        sensor = s; grant = g; reset = r;
        model_edge(s, g, r);
        exp_q.push_back({m_req, m_starve});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_req", {4'b0, req}, {4'b0, e[7:4]});
            check_eq("sb_starve", {4'b0, starve}, {4'b0, e[3:0]});
        end
    endtask

    task automatic steps(input int n, input logic [3:0] s, input logic [3:0] g);
        for (int i = 0; i < n; i++) step(s, g, 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'b0000, 1'b1);
            check_eq("rst_out", {req, starve}, 8'h00);
        end
    endtask

    initial begin
        for (int l = 0; l < 4; l++) begin
            m_hist[l] = '0; m_age[l] = 0; m_wait[l] = 0;
        end

        // 1: latency of a held sensor
        do_reset();
        steps(6, 4'b0010, 4'b0000);
        check_eq("t1_edge6", {4'b0, req}, 8'h00);
        steps(1, 4'b0010, 4'b0000);
        check_eq("t1_edge7", {4'b0, req}, 8'h02);

        // 2: short glitch rejected, minimum pulse accepted and held
        do_reset();
        steps(3, 4'b0100, 4'b0000);
        steps(12, 4'b0000, 4'b0000);
        check_eq("t2_glitch3", {7'b0, req[2]}, 8'h00);
        steps(4, 4'b0100, 4'b0000);
        steps(12, 4'b0000, 4'b0000);
        check_eq("t2_pulse4", {7'b0, req[2]}, 8'h01);

        // 3: grant clears a sticky request; held sensor re-requests
        do_reset();
        steps(8, 4'b0001, 4'b0000);
        steps(8, 4'b0000, 4'b0000);
        check_eq("t3_sticky", {7'b0, req[0]}, 8'h01);
        steps(1, 4'b0000, 4'b0001);
        check_eq("t3_grant", {7'b0, req[0]}, 8'h00);
        steps(5, 4'b0000, 4'b0000);
        check_eq("t3_stays0", {7'b0, req[0]}, 8'h00);
        steps(8, 4'b0001, 4'b0000);
        steps(1, 4'b0001, 4'b0001);
        check_eq("t3_grant_held", {7'b0, req[0]}, 8'h00);
        steps(1, 4'b0001, 4'b0000);
        check_eq("t3_rereq", {7'b0, req[0]}, 8'h01);

        // 4: starvation timing, saturation and clear on grant
        do_reset();
        steps(7, 4'b1000, 4'b0000);
        check_eq("t4_req_rose", {4'b0, req}, 8'h08);
        steps(19, 4'b0000, 4'b0000);
        check_eq("t4_edge19", {4'b0, starve}, 8'h00);
        steps(1, 4'b0000, 4'b0000);
        check_eq("t4_edge20", {4'b0, starve}, 8'h08);
        steps(100, 4'b0000, 4'b0000);
        check_eq("t4_saturated", {4'b0, starve}, 8'h08);
        steps(1, 4'b0000, 4'b1000);
        check_eq("t4_grant", {req[3], starve[3]}, 8'h00);

        // 5: rotating grant across all lanes
        do_reset();
        steps(7, 4'b1111, 4'b0000);
        check_eq("t5_all", {4'b0, req}, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] g;
            g = 4'b0001 << i;
            steps(1, 4'b1111, g);
            check_eq("t5_rot", {4'b0, req}, {4'b0, ~g});
        end
        steps(1, 4'b1111, 4'b0000);
        check_eq("t5_back", {4'b0, req}, 8'h0F);

        // 6: reset mid-debounce discards progress
        do_reset();
        steps(4, 4'b0010, 4'b0000);
        step(4'b0010, 4'b0000, 1'b1);
        check_eq("t6_rst", {req, starve}, 8'h00);
        steps(6, 4'b0010, 4'b0000);
        check_eq("t6_edge6", {4'b0, req}, 8'h00);
        steps(1, 4'b0010, 4'b0000);
        check_eq("t6_edge7", {4'b0, req}, 8'h02);

        // Random soak against the reference
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] s, g;
            s = (i % 16 < 9) ? 4'($urandom_range(0, 15)) : sensor;
            g = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(s, g, ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
